nibble_acc: RTL

- Downstream stage of the nibble adder. Consumes its 5-bit sum `q` through a valid/ready handshake.
- Accumulates a fixed burst of N_SAMPLES sums into a wider register, then presents the total with its own valid/ready handshake.
- Also tracks how many samples came from the high-nibble lane (`ctrl`=1) and flags arithmetic overflow.
- Sits between the adder and the result/display logic.

---
 rtl/nibble_pkg.sv | 13 +
 rtl/nibble_acc_add.sv | 27 ++
 rtl/nibble_acc.sv | 84 ++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// Shared types and constants for the nibble adder / accumulator pair.
package nibble_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int Q_W           = 5;
  localparam int N_SAMPLES_DEF = 4;

endpackage

// File: rtl/nibble_acc_add.sv
// Accumulator adder: carry detection plus wrap or saturate result selection.
// Saturation is selected by defining NIBBLE_ACC_SAT_EN.
module nibble_acc_add
  import nibble_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [Q_W-1:0]   q,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] wide;

  always_comb begin
    wide  = {1'b0, acc} + {{(ACC_W + 1 - Q_W){1'b0}}, q};
    carry = wide[ACC_W];
`ifdef NIBBLE_ACC_SAT_EN
    // Once saturated, any further non-zero add carries again and stays at all ones.
    sum = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    sum = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/nibble_acc.sv
// Burst accumulator for nibble adder sums with lane counting and sticky overflow.
// Optional saturating arithmetic via NIBBLE_ACC_SAT_EN (see nibble_acc_add).
module nibble_acc
  import nibble_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int ACC_W     = 8,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [Q_W-1:0]   q_in,
  input  logic             ctrl_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic [CNT_W-1:0] hi_cnt,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_t           state_reg;
  logic [ACC_W-1:0] sum_reg;
  logic [CNT_W-1:0] hi_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;

  logic [ACC_W-1:0] add_sum;
  logic             add_carry;

  nibble_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc   (sum_reg),
    .q     (q_in),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sum_reg   <= '0;
      hi_reg    <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= ACCUM;
            sum_reg   <= '0;
            hi_reg    <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            sum_reg <= add_sum;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (add_carry) ovf_reg <= 1'b1;
            if (ctrl_in)   hi_reg  <= hi_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(N_SAMPLES - 1)) state_reg <= DONE;
          end
        end
        DONE: begin
          // Result registers are left untouched so the total stays readable until the next start.
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == ACCUM) || (state_reg == DONE);
  assign sum_out   = sum_reg;
  assign hi_cnt    = hi_reg;
  assign overflow  = ovf_reg;

endmodule
